// File: rtl/cdu_drive_gen.sv
// cdu_drive_gen: multi-channel CDU drive pulse generator stepping signed counts toward zero.
// Define CDU_DRIVE_ACCUM_EN to make loads add (saturating) instead of replace.
module cdu_drive_gen #(
  parameter int NCH = 3,
  parameter int CNT_W = 8,
  parameter int PULSE_DIV = 16,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    CLOCK,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic signed [CNT_W-1:0] wr_data,
  input  logic [NCH-1:0]          drv_en,
  output logic [NCH-1:0]          DRP,
  output logic [NCH-1:0]          DRM,
  output logic [NCH-1:0]          busy,
  output logic [NCH-1:0]          done,
  input  logic [CH_W-1:0]         rd_ch,
  output logic signed [CNT_W-1:0] rd_data
);
  localparam int DIV_W = $clog2(PULSE_DIV);
  logic [DIV_W-1:0] r_div;
  logic w_tick;
  logic signed [CNT_W-1:0] w_cnt [NCH];
  assign w_tick = r_div == DIV_W'(PULSE_DIV - 1);
  always_ff @(posedge CLOCK) r_div <= (rst || w_tick) ? '0 : r_div + DIV_W'(1);
  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      logic signed [CNT_W-1:0] r_cnt, w_ld_val;
      logic r_p, r_m, r_d, w_ld, w_step, w_pos;
      assign w_ld = wr_en && wr_ch == CH_W'(c);
      assign w_step = w_tick && drv_en[c] && r_cnt != '0 && !w_ld;
      assign w_pos = !r_cnt[CNT_W-1];
`ifdef CDU_DRIVE_ACCUM_EN
      localparam logic signed [CNT_W:0] S_MAX = (CNT_W+1)'((1 << (CNT_W - 1)) - 1);
      localparam logic signed [CNT_W:0] S_MIN = -S_MAX - (CNT_W+1)'(1);
      logic signed [CNT_W:0] w_sum;
      assign w_sum = {r_cnt[CNT_W-1], r_cnt} + {wr_data[CNT_W-1], wr_data};
      assign w_ld_val = (w_sum > S_MAX) ? S_MAX[CNT_W-1:0] :
                        (w_sum < S_MIN) ? S_MIN[CNT_W-1:0] : w_sum[CNT_W-1:0];
`else
      assign w_ld_val = wr_data;
`endif
      always_ff @(posedge CLOCK) begin
        if (rst) begin
          r_cnt <= '0;
          r_p <= 1'b0;
          r_m <= 1'b0;
          r_d <= 1'b0;
        end else begin
          r_cnt <= w_ld ? w_ld_val : w_step ? (w_pos ? r_cnt - CNT_W'(1) : r_cnt + CNT_W'(1)) : r_cnt;
          r_p <= w_step && w_pos;
          r_m <= w_step && !w_pos;
          r_d <= w_step && (r_cnt == (w_pos ? CNT_W'(1) : '1));
        end
      end
      assign w_cnt[c] = r_cnt;
      assign DRP[c] = r_p;
      assign DRM[c] = r_m;
      assign done[c] = r_d;
      assign busy[c] = r_cnt != '0;
    end
  endgenerate
  assign rd_data = (32'(rd_ch) < NCH) ? w_cnt[rd_ch] : '0;
endmodule

// File: tb/tb_cdu_drive_gen.sv
// tb_cdu_drive_gen: randomized and directed checks of cdu_drive_gen against a count-level model.
module tb_cdu_drive_gen;
  localparam int NCH = 3, W = 8, PD = 16;
  logic CLOCK = 1'b0, rst = 1'b1, wr_en = 1'b0;
  logic [1:0] wr_ch = '0, rd_ch = '0;
  logic signed [W-1:0] wr_data = '0;
  logic [NCH-1:0] drv_en = '0;
  logic [NCH-1:0] DRP, DRM, busy, done;
  logic signed [W-1:0] rd_data;
  int checks = 0, failures = 0;
  int m_cnt [NCH];
  int m_div = 0;
  logic [NCH-1:0] e_p = '0, e_m = '0, e_d = '0;

  cdu_drive_gen #(.NCH(NCH), .CNT_W(W), .PULSE_DIV(PD)) dut (
    .CLOCK(CLOCK), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .drv_en(drv_en), .DRP(DRP), .DRM(DRM), .busy(busy), .done(done),
    .rd_ch(rd_ch), .rd_data(rd_data));

  always #5 CLOCK = ~CLOCK;

  function automatic int load_val(int cur, int d);
`ifdef CDU_DRIVE_ACCUM_EN
    int v = cur + d;
    return v > 127 ? 127 : v < -128 ? -128 : v;
`else
    return d;
`endif
  endfunction

  // Advance one clock and update the reference model from the inputs sampled at that edge.
  task automatic cyc();
    bit tick;
    @(posedge CLOCK);
    tick = (m_div == PD - 1);
    for (int c = 0; c < NCH; c++) begin
      bit ld = wr_en && (int'(wr_ch) == c);
      bit st = tick && drv_en[c] && m_cnt[c] != 0 && !ld;
      e_p[c] = st && m_cnt[c] > 0;
      e_m[c] = st && m_cnt[c] < 0;
      m_cnt[c] = ld ? load_val(m_cnt[c], int'(wr_data)) : st ? m_cnt[c] - (m_cnt[c] > 0 ? 1 : -1) : m_cnt[c];
      e_d[c] = st && m_cnt[c] == 0;
    end
    m_div = (m_div + 1) % PD;
    if (rst) begin
      m_div = 0;
      e_p = '0; e_m = '0; e_d = '0;
      for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
    end
    #1;
  endtask

  function automatic logic [4*NCH-1:0] exp_out();
    logic [NCH-1:0] b;
    for (int c = 0; c < NCH; c++) b[c] = m_cnt[c] != 0;
    return {e_p, e_m, e_d, b};
  endfunction

  function automatic logic [W-1:0] exp_rd();
    return int'(rd_ch) < NCH ? W'(m_cnt[rd_ch]) : '0;
  endfunction

  task automatic load(int ch, int d);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_data = W'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({DRP, DRM, done, busy, rd_data} !== '0) begin
      failures++; $display("FAIL reset_init: got %h want 0", {DRP, DRM, done, busy, rd_data});
    end
    rst = 1'b0; drv_en = '1;
    load(0, 5);
    repeat (20) cyc();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({DRP, DRM, done, busy, rd_data} !== '0) begin
      failures++; $display("FAIL reset_mid: got %h want 0", {DRP, DRM, done, busy, rd_data});
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * PD; i++) begin
      cyc();
      checks++;
      if ({DRP, DRM, busy} !== '0) begin
        failures++; $display("FAIL reset_quiet: cycle %0d got %b want 0", i, {DRP, DRM, busy});
      end
    end
  endtask

  task automatic test_plus();
    int np = 0, nm = 0, nd = 0, t [$];
    do_reset();
    drv_en = '1; rd_ch = 2'd1;
    load(1, 3);
    for (int i = 0; i < 80; i++) begin
      cyc();
      checks++;
      if ({DRP, DRM, done, busy} !== exp_out()) begin
        failures++; $display("FAIL plus_cycle: got %b want %b", {DRP, DRM, done, busy}, exp_out());
      end
      if (DRP[1]) begin np++; t.push_back(i); end
      if (DRM != '0) nm++;
      if (done[1]) begin
        nd++;
        checks++;
        if (np != 3 || busy[1] !== 1'b0) begin
          failures++; $display("FAIL plus_done: pulses %0d busy %b want 3 0", np, busy[1]);
        end
      end
    end
    checks++;
    if (np != 3 || nm != 0 || nd != 1) begin
      failures++; $display("FAIL plus_count: drp %0d drm %0d done %0d want 3 0 1", np, nm, nd);
    end
    checks++;
    if (t.size() != 3 || t[1] - t[0] != PD || t[2] - t[1] != PD) begin
      failures++; $display("FAIL plus_spacing: got %0d pulses gaps want %0d", t.size(), PD);
    end
  endtask

  task automatic test_min_neg();
    int nm = 0, np = 0, nd = 0;
    do_reset();
    drv_en = 3'b001; rd_ch = 2'd0;
    load(0, -128);
    checks++;
    if (rd_data !== -8'sd128 || busy[0] !== 1'b1) begin
      failures++; $display("FAIL neg_load: got %0d busy %b want -128 1", rd_data, busy[0]);
    end
    for (int i = 0; i < 128 * PD + 40; i++) begin
      cyc();
      checks++;
      if ({DRP, DRM, done, busy, rd_data} !== {exp_out(), exp_rd()}) begin
        failures++; $display("FAIL neg_cycle: got %h want %h", {DRP, DRM, done, busy, rd_data}, {exp_out(), exp_rd()});
      end
      nm += int'(DRM[0]); np += int'(DRP[0]); nd += int'(done[0]);
    end
    checks++;
    if (nm != 128 || np != 0 || nd != 1 || rd_data !== '0) begin
      failures++; $display("FAIL neg_count: drm %0d drp %0d done %0d rd %0d want 128 0 1 0", nm, np, nd, rd_data);
    end
  endtask

  task automatic test_enable();
    int np = 0, lim = 0;
    do_reset();
    drv_en = '1; rd_ch = 2'd2;
    load(2, 4);
    while (np < 2 && lim < 80) begin
      cyc(); lim++;
      np += int'(DRP[2]);
    end
    checks++;
    if (np != 2) begin
      failures++; $display("FAIL en_first: pulses %0d want 2", np);
    end
    drv_en[2] = 1'b0;
    np = 0;
    repeat (50) begin
      cyc();
      np += int'(DRP[2]) + int'(DRM[2]);
    end
    checks++;
    if (np != 0 || rd_data !== 8'sd2 || busy[2] !== 1'b1) begin
      failures++; $display("FAIL en_hold: pulses %0d rd %0d busy %b want 0 2 1", np, rd_data, busy[2]);
    end
    drv_en[2] = 1'b1;
    np = 0; lim = 0;
    while (!done[2] && lim < 80) begin
      cyc(); lim++;
      np += int'(DRP[2]);
    end
    checks++;
    if (np != 2 || !done[2] || rd_data !== '0) begin
      failures++; $display("FAIL en_resume: pulses %0d done %b rd %0d want 2 1 0", np, done[2], rd_data);
    end
  endtask

  task automatic test_load_on_tick();
    int lim = 0;
    do_reset();
    drv_en = '1; rd_ch = 2'd1;
    load(1, 5);
    while (m_div != PD - 1 && lim < 40) begin cyc(); lim++; end
    load(1, 2);
    checks++;
`ifdef CDU_DRIVE_ACCUM_EN
    if (DRP[1] !== 1'b0 || rd_data !== 8'sd7) begin
      failures++; $display("FAIL tick_load: drp %b rd %0d want 0 7", DRP[1], rd_data);
    end
`else
    if (DRP[1] !== 1'b0 || rd_data !== 8'sd2) begin
      failures++; $display("FAIL tick_load: drp %b rd %0d want 0 2", DRP[1], rd_data);
    end
`endif
    repeat (PD) cyc();
    checks++;
    if ({DRP, DRM, done, busy, rd_data} !== {exp_out(), exp_rd()}) begin
      failures++; $display("FAIL tick_after: got %h want %h", {DRP, DRM, done, busy, rd_data}, {exp_out(), exp_rd()});
    end
  endtask

  task automatic test_bad_ch();
    int want [NCH] = '{10, -3, 7};
    do_reset();
    drv_en = '0;
    for (int c = 0; c < NCH; c++) load(c, want[c]);
    load(3, 55);
    for (int c = 0; c < NCH; c++) begin
      rd_ch = 2'(c);
      #1;
      checks++;
      if (rd_data !== W'(want[c])) begin
        failures++; $display("FAIL bad_ch: ch %0d got %0d want %0d", c, rd_data, want[c]);
      end
    end
    rd_ch = 2'd3;
    #1;
    checks++;
    if (busy !== 3'b111 || rd_data !== '0) begin
      failures++; $display("FAIL bad_ch_rd: busy %b rd %0d want 111 0", busy, rd_data);
    end
  endtask

  task automatic test_cancel();
    int np = 0, nd = 0, lim = 0;
    do_reset();
    drv_en = '1; rd_ch = 2'd0;
    load(0, 6);
    while (np < 2 && lim < 80) begin cyc(); lim++; np += int'(DRP[0]); end
`ifdef CDU_DRIVE_ACCUM_EN
    load(0, -4);
`else
    load(0, 0);
`endif
    np = 0;
    repeat (40) begin cyc(); np += int'(DRP[0]); nd += int'(done[0]); end
    checks++;
    if (np != 0 || nd != 0 || busy[0] !== 1'b0 || rd_data !== '0) begin
      failures++; $display("FAIL cancel: drp %0d done %0d busy %b rd %0d want 0 0 0 0", np, nd, busy[0], rd_data);
    end
  endtask

`ifdef CDU_DRIVE_ACCUM_EN
  task automatic test_accum();
    do_reset();
    drv_en = '0; rd_ch = 2'd1;
    load(1, 100);
    load(1, 100);
    checks++;
    if (rd_data !== 8'sd127) begin
      failures++; $display("FAIL accum_sat: got %0d want 127", rd_data);
    end
    load(1, -27);
    checks++;
    if (rd_data !== 8'sd100) begin
      failures++; $display("FAIL accum_sub: got %0d want 100", rd_data);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(3) == 0);
      wr_ch = 2'($urandom_range(3));
      wr_data = W'($urandom_range(255));
      if ($urandom_range(19) == 0) drv_en = NCH'($urandom_range(7));
      rd_ch = 2'($urandom_range(3));
      rst = ($urandom_range(299) == 0);
      cyc();
      checks++;
      if ({DRP, DRM, done, busy, rd_data} !== {exp_out(), exp_rd()}) begin
        failures++; $display("FAIL random: cycle %0d got %h want %h", i, {DRP, DRM, done, busy, rd_data}, {exp_out(), exp_rd()});
      end
      checks++;
      if ((DRP & DRM) !== '0) begin
        failures++; $display("FAIL random_excl: got %b want 000", DRP & DRM);
      end
    end
    rst = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_plus();
    test_min_neg();
    test_enable();
    test_load_on_tick();
    test_bad_ch();
    test_cancel();
`ifdef CDU_DRIVE_ACCUM_EN
    test_accum();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
